// File: rtl/memory_bus_responder_pkg.sv
// Shared widths, state/byte-enable encodings and access-control payload
// for the memory bus responder.
package memory_bus_responder_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned BE_W   = 2;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned ST_W   = 2;

   localparam logic [ST_W-1:0] BUS_STATE_IDLE   = 2'd0;
   localparam logic [ST_W-1:0] BUS_STATE_ACCESS = 2'd1;
   localparam logic [ST_W-1:0] BUS_STATE_DONE   = 2'd2;

   localparam logic [BE_W-1:0] BUS_BE_LO   = 2'b01;
   localparam logic [BE_W-1:0] BUS_BE_HI   = 2'b10;
   localparam logic [BE_W-1:0] BUS_BE_WORD = 2'b11;

   // Per-access lane info kept for read-data extraction and error reporting
   typedef struct packed {
      logic rd;
      logic byte_acc;
      logic odd;
   } acc_ctrl_t;

   // A request is legal only when exactly one of read/write is asserted
   function automatic logic req_legal(input logic rdx, input logic wrx);
      return rdx ^ wrx;
   endfunction

endpackage

// File: rtl/memory_bus_responder_if.sv
// Core-side request/response and memory-side strobe signals of the responder.
interface memory_bus_responder_if #(
   parameter int unsigned ADDR_W = 16
);
   logic              start;
   logic              rdx;
   logic              wrx;
   logic              bytex;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       wdata;
   logic [15:0]       rdata;
   logic              done;
   logic              bus_err;
   logic              busy;
   logic [ADDR_W-2:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic [1:0]        mem_be;
   logic              mem_rd;
   logic              mem_wr;
   logic [15:0]       mem_rdata;
   logic              mem_ready;

   // Core plus memory side: issues requests and answers memory strobes
   modport master (
      output start, rdx, wrx, bytex, addr, wdata, mem_rdata, mem_ready,
      input  rdata, done, bus_err, busy, mem_addr, mem_wdata, mem_be, mem_rd, mem_wr
   );

   // Responder
   modport slave (
      input  start, rdx, wrx, bytex, addr, wdata, mem_rdata, mem_ready,
      output rdata, done, bus_err, busy, mem_addr, mem_wdata, mem_be, mem_rd, mem_wr
   );
endinterface

// File: rtl/memory_bus_responder_byte_lane_steer.sv
// Little-endian byte-lane steering: write data/byte-enable generation and
// read-data lane extraction with zero extension.
module memory_bus_responder_byte_lane_steer
   import memory_bus_responder_pkg::*;
(
   input  logic              wr_byte,
   input  logic              wr_odd,
   input  logic [DATA_W-1:0] wdata,
   input  logic              rd_byte,
   input  logic              rd_odd,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [BE_W-1:0]   be_c,
   output logic [DATA_W-1:0] lane_wdata_c,
   output logic [DATA_W-1:0] lane_rdata_c
);

   // Write direction: a byte is replicated on both lanes, BE picks the lane
   always_comb begin
      be_c         = BUS_BE_WORD;
      lane_wdata_c = wdata;
      if (wr_byte) begin
         be_c         = wr_odd ? BUS_BE_HI : BUS_BE_LO;
         lane_wdata_c = {wdata[7:0], wdata[7:0]};
      end
   end

   // Read direction: select the addressed lane and zero-extend
   always_comb begin
      lane_rdata_c = mem_rdata;
      if (rd_byte) begin
         lane_rdata_c = rd_odd ? {8'h00, mem_rdata[15:8]} : {8'h00, mem_rdata[7:0]};
      end
   end

endmodule

// File: rtl/memory_bus_responder.sv
// Memory-side endpoint: runs one load/store against a wait-stated 16-bit
// word memory and reports completion, read data and errors to the core.
module memory_bus_responder
   import memory_bus_responder_pkg::*;
#(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    rst_n,
   memory_bus_responder_if.slave   bus
);

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
   localparam int unsigned      MADDR_W     = ADDR_W - 1;

   logic [ST_W-1:0]    state, state_nx;
   logic [CNT_W-1:0]   wait_cnt, wait_cnt_nx;
   acc_ctrl_t          acc, acc_nx;
   logic [DATA_W-1:0]  rdata_q, rdata_nx;
   logic               done_q, done_nx;
   logic               err_q, err_nx;
   logic               busy_q, busy_nx;
   logic [MADDR_W-1:0] maddr_q, maddr_nx;
   logic [DATA_W-1:0]  mwdata_q, mwdata_nx;
   logic [BE_W-1:0]    mbe_q, mbe_nx;
   logic               mrd_q, mrd_nx;
   logic               mwr_q, mwr_nx;

   logic [BE_W-1:0]    lane_be_c;
   logic [DATA_W-1:0]  lane_wdata_c;
   logic [DATA_W-1:0]  lane_rdata_c;
   logic               misaligned_c;

   assign misaligned_c = !acc.byte_acc && acc.odd;

   // Write steering follows the live request; read extraction uses the latched access
   memory_bus_responder_byte_lane_steer u_byte_lane_steer (
      .wr_byte      (bus.bytex),
      .wr_odd       (bus.addr[0]),
      .wdata        (bus.wdata),
      .rd_byte      (acc.byte_acc),
      .rd_odd       (acc.odd),
      .mem_rdata    (bus.mem_rdata),
      .be_c         (lane_be_c),
      .lane_wdata_c (lane_wdata_c),
      .lane_rdata_c (lane_rdata_c)
   );

   // Next-state and next-output logic
   always_comb begin
      state_nx    = state;
      wait_cnt_nx = wait_cnt;
      acc_nx      = acc;
      rdata_nx    = rdata_q;
      done_nx     = 1'b0;
      err_nx      = 1'b0;
      maddr_nx    = maddr_q;
      mwdata_nx   = mwdata_q;
      mbe_nx      = mbe_q;
      mrd_nx      = mrd_q;
      mwr_nx      = mwr_q;

      case (state)
         BUS_STATE_IDLE: begin
            if (bus.start) begin
               if (req_legal(bus.rdx, bus.wrx)) begin
                  state_nx        = BUS_STATE_ACCESS;
                  wait_cnt_nx     = '0;
                  acc_nx.rd       = bus.rdx;
                  acc_nx.byte_acc = bus.bytex;
                  acc_nx.odd      = bus.addr[0];
                  maddr_nx        = bus.addr[ADDR_W-1:1];
                  mbe_nx          = lane_be_c;
                  mwdata_nx       = lane_wdata_c;
                  mrd_nx          = bus.rdx;
                  mwr_nx          = bus.wrx;
               end else begin
                  state_nx = BUS_STATE_DONE;
                  done_nx  = 1'b1;
                  err_nx   = 1'b1;
               end
            end
         end

         BUS_STATE_ACCESS: begin
            // READY wins over a timeout landing in the same cycle
            if (bus.mem_ready) begin
               state_nx = BUS_STATE_DONE;
               done_nx  = 1'b1;
               err_nx   = misaligned_c;
               mrd_nx   = 1'b0;
               mwr_nx   = 1'b0;
               if (acc.rd) begin
                  rdata_nx = lane_rdata_c;
               end
            end else if (wait_cnt == TIMEOUT_CNT) begin
               state_nx = BUS_STATE_DONE;
               done_nx  = 1'b1;
               err_nx   = 1'b1;
               mrd_nx   = 1'b0;
               mwr_nx   = 1'b0;
               if (acc.rd) begin
                  rdata_nx = '0;
               end
            end else begin
               wait_cnt_nx = wait_cnt + CNT_W'(1);
            end
         end

         BUS_STATE_DONE: begin
            state_nx = BUS_STATE_IDLE;
         end

         default: begin
            state_nx = BUS_STATE_IDLE;
            mrd_nx   = 1'b0;
            mwr_nx   = 1'b0;
         end
      endcase

      busy_nx = (state_nx != BUS_STATE_IDLE);
   end

   // State register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= BUS_STATE_IDLE;
         wait_cnt <= '0;
         acc      <= '0;
         rdata_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         maddr_q  <= '0;
         mwdata_q <= '0;
         mbe_q    <= '0;
         mrd_q    <= 1'b0;
         mwr_q    <= 1'b0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_cnt_nx;
         acc      <= acc_nx;
         rdata_q  <= rdata_nx;
         done_q   <= done_nx;
         err_q    <= err_nx;
         busy_q   <= busy_nx;
         maddr_q  <= maddr_nx;
         mwdata_q <= mwdata_nx;
         mbe_q    <= mbe_nx;
         mrd_q    <= mrd_nx;
         mwr_q    <= mwr_nx;
      end
   end

   assign bus.rdata     = rdata_q;
   assign bus.done      = done_q;
   assign bus.bus_err   = err_q;
   assign bus.busy      = busy_q;
   assign bus.mem_addr  = maddr_q;
   assign bus.mem_wdata = mwdata_q;
   assign bus.mem_be    = mbe_q;
   assign bus.mem_rd    = mrd_q;
   assign bus.mem_wr    = mwr_q;

endmodule

// File: tb/tb_memory_bus_responder.sv
// Scoreboard bench for memory_bus_responder: directed accesses push expected
// completions; a negedge monitor pops and compares on every DONE pulse.
module tb_memory_bus_responder;

   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned TIMEOUT = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   memory_bus_responder_if #(.ADDR_W(ADDR_W)) bus ();

   memory_bus_responder #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      int          lat;
      longint      t0;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   rd_cyc   = 0;
   int   wr_cyc   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Strobe-cycle counters and scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (bus.mem_rd) rd_cyc++;
      if (bus.mem_wr) wr_cyc++;
      if (rst_n && bus.done) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
         end else begin
            e = sb.pop_front();
            check({e.name, "_rdata"}, 32'(bus.rdata), 32'(e.rdata));
            check({e.name, "_err"}, 32'(bus.bus_err), 32'(e.err));
            check({e.name, "_lat"}, 32'(int'((longint'($time) - e.t0 + 5) / 10)), 32'(e.lat));
         end
      end
   end

   // waits: cycles of READY=0 before READY=1; negative keeps READY low
   task automatic run_access(
      input string       name,
      input logic        rdx, input logic wrx, input logic bytex,
      input logic [15:0] addr, input logic [15:0] wdata, input logic [15:0] mrdata,
      input int          waits,
      input logic        chk_mem,
      input logic [14:0] e_maddr, input logic [1:0] e_be, input logic [15:0] e_mwdata,
      input logic [15:0] e_rdata, input logic e_err, input int e_lat,
      input int          e_rd, input int e_wr
   );
      exp_t e;
      bit   idle_seen;
      @(negedge clk);
      rd_cyc = 0;
      wr_cyc = 0;
      bus.start = 1'b1; bus.rdx = rdx; bus.wrx = wrx; bus.bytex = bytex;
      bus.addr = addr; bus.wdata = wdata; bus.mem_rdata = mrdata; bus.mem_ready = 1'b0;
      @(posedge clk);
      e.rdata = e_rdata; e.err = e_err; e.lat = e_lat; e.t0 = longint'($time); e.name = name;
      sb.push_back(e);
      #1;
      bus.start = 1'b0; bus.rdx = 1'b0; bus.wrx = 1'b0;
      if (chk_mem) begin
         check({name, "_maddr"}, 32'(bus.mem_addr), 32'(e_maddr));
         check({name, "_be"}, 32'(bus.mem_be), 32'(e_be));
         if (wrx) check({name, "_mwdata"}, 32'(bus.mem_wdata), 32'(e_mwdata));
      end
      if (waits == 0) bus.mem_ready = 1'b1;
      else if (waits > 0) begin
         repeat (waits) @(posedge clk);
         #1 bus.mem_ready = 1'b1;
      end
      idle_seen = 1'b0;
      for (int i = 0; i < 40 && !idle_seen; i++) begin
         @(negedge clk);
         idle_seen = !bus.busy;
      end
      bus.mem_ready = 1'b0;
      check({name, "_idle"}, 32'(idle_seen), 32'd1);
      check({name, "_rd_cycles"}, 32'(rd_cyc), 32'(e_rd));
      check({name, "_wr_cycles"}, 32'(wr_cyc), 32'(e_wr));
      check({name, "_rd_after"}, 32'(bus.mem_rd), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.start = 1'b0; bus.rdx = 1'b0; bus.wrx = 1'b0; bus.bytex = 1'b0;
      bus.addr = '0; bus.wdata = '0; bus.mem_rdata = '0; bus.mem_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_rdata", 32'(bus.rdata), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
      check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
      check("rst_mem_be", 32'(bus.mem_be), 32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      //          name        rd   wr   byte addr      wdata     mrdata    wt  chk  maddr     be     mwdata    rdata     err  lat rd wr
      run_access("wrd_rd",    1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'hBEEF, 0, 1'b1, 15'h0080, 2'b11, 16'h0000, 16'hBEEF, 1'b0, 2, 1, 0);
      run_access("byte_odd",  1'b1, 1'b0, 1'b1, 16'h0101, 16'h0000, 16'h12AB, 3, 1'b1, 15'h0080, 2'b10, 16'h0000, 16'h0012, 1'b0, 5, 4, 0);
      run_access("bwr_even",  1'b0, 1'b1, 1'b1, 16'h0204, 16'h55C3, 16'hFFFF, 0, 1'b1, 15'h0102, 2'b01, 16'hC3C3, 16'h0012, 1'b0, 2, 0, 1);
      run_access("tmo_rd",    1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h9999, -1, 1'b1, 15'h0008, 2'b11, 16'h0000, 16'h0000, 1'b1, 6, 5, 0);
      run_access("ill_both",  1'b1, 1'b1, 1'b0, 16'h0050, 16'h1111, 16'h2222, -1, 1'b0, 15'h0000, 2'b00, 16'h0000, 16'h0000, 1'b1, 1, 0, 0);
      run_access("ill_none",  1'b0, 1'b0, 1'b0, 16'h0052, 16'h1111, 16'h2222, -1, 1'b0, 15'h0000, 2'b00, 16'h0000, 16'h0000, 1'b1, 1, 0, 0);
      run_access("misal_rd",  1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000, 16'hA55A, 0, 1'b1, 15'h0001, 2'b11, 16'h0000, 16'hA55A, 1'b1, 2, 1, 0);
      run_access("wwr_wait",  1'b0, 1'b1, 1'b0, 16'h0006, 16'h1234, 16'h0000, 1, 1'b1, 15'h0003, 2'b11, 16'h1234, 16'hA55A, 1'b0, 3, 0, 2);
      run_access("byte_even", 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'h77E1, 0, 1'b1, 15'h0020, 2'b01, 16'h0000, 16'h00E1, 1'b0, 2, 1, 0);
      run_access("bwr_odd",   1'b0, 1'b1, 1'b1, 16'h0041, 16'hAA5B, 16'h0000, 0, 1'b1, 15'h0020, 2'b10, 16'h5B5B, 16'h00E1, 1'b0, 2, 0, 1);
      run_access("rdy_at_to", 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'hCAFE, 4, 1'b1, 15'h0010, 2'b11, 16'h0000, 16'hCAFE, 1'b0, 6, 5, 0);

      // Reset asserted while the access is waiting on READY
      @(negedge clk);
      bus.start = 1'b1; bus.rdx = 1'b1; bus.wrx = 1'b0; bus.bytex = 1'b0;
      bus.addr = 16'h0200; bus.mem_ready = 1'b0;
      @(posedge clk);
      #1 bus.start = 1'b0; bus.rdx = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("rstmid_pre_rd", 32'(bus.mem_rd), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rstmid_mem_rd", 32'(bus.mem_rd), 32'd0);
      check("rstmid_busy", 32'(bus.busy), 32'd0);
      check("rstmid_done", 32'(bus.done), 32'd0);
      check("rstmid_rdata", 32'(bus.rdata), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_access("post_rst",  1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'hBEEF, 0, 1'b1, 15'h0080, 2'b11, 16'h0000, 16'hBEEF, 1'b0, 2, 1, 0);

      repeat (3) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
